store_align_unit: RTL and testbench
===================================

// Module: store_align_unit
// PURPOSE
//  Write-side counterpart of the load extender: narrows sb/sh/sw store data onto the 32-bit bus.
//  Replicates byte/halfword data across lanes and generates byte enables from addr[1:0].
//  Holds one store in a registered req/ack handshake until the data memory or bridge accepts it.
//  Sits between the MEM stage and DM/bridge.
// PARAMETERS
//  TIMEOUT  16  ack wait limit in cycles, range 0..255; 0 = wait forever
// PORTS
//  clk        in   1   clock; all state changes on rising edge
//  reset      in   1   synchronous, active-high reset
//  in_valid   in   1   MEM stage presents a store this cycle
//  in_ready   out  1   unit can accept a store (combinational: state==IDLE)
//  in_addr    in   32  byte address of store
//  in_data    in   32  register data; low byte/half used for sb/sh
//  in_type    in   2   00=SW 01=SH 10=SB 11=reserved
//  m_req      out  1   registered write request to memory
//  m_ack      in   1   memory accepts the write this cycle
//  m_addr     out  32  word address {in_addr[31:2],2'b00}
//  m_wdata    out  32  lane-replicated write data
//  m_byteen   out  4   byte enables; 4'b0000 whenever m_req=0
//  exc_ades   out  1   one-cycle pulse: misaligned store (see CONFIGURATION)
//  bus_err    out  1   one-cycle pulse: ack timeout
// BEHAVIOUR
//  Reset: state=IDLE; m_req, m_addr, m_wdata, m_byteen, exc_ades, bus_err, counter all 0.
//  Reset in WAIT drops the pending store; no m_req on the following cycle.
//  FSM states: IDLE, WAIT.
//  IDLE: in_ready=1. Accept on in_valid at edge N. Valid aligned store: latch outputs, m_req=1 from N+1, go WAIT.
//  Lane mapping, b=addr[1:0]:
//   SW: wdata=data, byteen=1111.
//   SH: wdata={2{data[15:0]}}, byteen = b[1] ? 1100 : 0011.
//   SB: wdata={4{data[7:0]}}, byteen = 0001<<b.
//  Type 11: accepted and discarded; no m_req, no exception; stays IDLE.
//  WAIT: in_ready=0. m_addr/m_wdata/m_byteen held stable while m_req=1.
//   m_ack sampled high at edge: m_req=0 and m_byteen=0 next cycle; go IDLE.
//   New store accepted at the earliest one cycle after the ack edge; no back-to-back in the ack cycle.
//  Timeout (TIMEOUT>0): counter clears on entering WAIT and increments each WAIT cycle without m_ack.
//   After TIMEOUT cycles with no ack: bus_err=1 for one cycle, m_req=0, go IDLE.
//   m_ack on the same edge as expiry counts as success; no bus_err.
//  m_ack while in IDLE is ignored.
//  exc_ades and bus_err are registered one-cycle pulses, never asserted together.
// CONFIGURATION
//  STORE_ALIGN_EXC_EN defined:
//   SW with b!=00, or SH with b[0]=1: accepted, no m_req, exc_ades=1 at N+1, stays IDLE.
//  STORE_ALIGN_EXC_EN undefined:
//   exc_ades tied 0. Misaligned bits ignored: SW uses b=00, SH uses b[0]=0; store is performed.
// TESTING
//  SB addr=0x1003 data=0x000000AB -> N+1: m_req=1, m_addr=0x1000, m_wdata=0xABABABAB, m_byteen=1000.
//  SH addr=0x2002 data=0x1234 -> m_wdata=0x12341234, m_byteen=1100; ack after 3 cycles; in_ready returns next cycle.
//  SW addr=0x3001, macro on -> exc_ades pulse at N+1, no m_req; macro off -> m_addr=0x3000, m_byteen=1111.
//  TIMEOUT=4, m_ack held 0 -> bus_err pulse after 4 WAIT cycles, m_req=0, in_ready=1.
//  reset asserted in WAIT -> next cycle m_req=0, m_byteen=0; late m_ack is ignored.
//  type=11 with in_valid -> no m_req, no exc_ades, in_ready stays 1.

Source files
------------

// File: rtl/store_align_unit.sv
// store_align_unit: narrows SB/SH/SW store data onto the 32-bit data bus.
// It replicates the data across lanes, builds byte enables from addr[1:0],
// and holds one store on a registered req/ack handshake until memory
// accepts it or the ack wait times out.
//
// Handshakes:
//   in_valid/in_ready: a store is taken on a rising edge where both are 1.
//   m_req/m_ack: m_req stays high with stable addr/data/enables until
//   m_ack is seen at a rising edge.
//
// Optional feature: define STORE_ALIGN_EXC_EN to raise exc_ades on
// misaligned SW/SH and drop the store. When it is undefined, the misaligned
// address bits are ignored and the store is performed.
module store_align_unit #(
    parameter int unsigned TIMEOUT = 16  // ack wait limit in cycles (0..255), 0 = no limit
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_type,
    output logic        m_req,
    input  logic        m_ack,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_byteen,
    output logic        exc_ades,
    output logic        bus_err,
    output logic [0:0]  dbg_state
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam logic [1:0] T_SW = 2'b00;
    localparam logic [1:0] T_SH = 2'b01;
    localparam logic [1:0] T_SB = 2'b10;

    // Counter value on the edge that completes the TIMEOUT-th ack-less WAIT cycle.
    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
    localparam bit         TO_EN   = (TIMEOUT != 0);

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        m_req_q, m_req_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_byteen_q, m_byteen_d;
    logic        exc_q, exc_d;
    logic        bus_err_q, bus_err_d;

    logic [1:0]  b;
    logic        misaligned;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_byteen;

    // Lane replication and byte-enable generation for the presented store.
    always_comb begin
        b           = in_addr[1:0];
        lane_wdata  = in_data;
        lane_byteen = 4'b1111;
        case (in_type)
            T_SH: begin
                lane_wdata  = {2{in_data[15:0]}};
                lane_byteen = b[1] ? 4'b1100 : 4'b0011;
            end
            T_SB: begin
                lane_wdata  = {4{in_data[7:0]}};
                lane_byteen = 4'b0001 << b;
            end
            default: begin
                lane_wdata  = in_data;
                lane_byteen = 4'b1111;
            end
        endcase
`ifdef STORE_ALIGN_EXC_EN
        misaligned = ((in_type == T_SW) && (b != 2'b00)) ||
                     ((in_type == T_SH) && b[0]);
`else
        // Low address bits below the access size are simply dropped.
        misaligned = 1'b0;
`endif
    end

    // Next-state logic for the IDLE/WAIT handshake FSM and its outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_req_d    = m_req_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_byteen_d = m_byteen_q;
        exc_d      = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && (in_type != 2'b11)) begin
                    if (misaligned) begin
                        exc_d = 1'b1;
                    end else begin
                        m_req_d    = 1'b1;
                        m_addr_d   = {in_addr[31:2], 2'b00};
                        m_wdata_d  = lane_wdata;
                        m_byteen_d = lane_byteen;
                        cnt_d      = 8'd0;
                        state_d    = WAIT;
                    end
                end
            end
            default: begin
                if (m_ack) begin
                    // An ack on the expiry edge still counts as success.
                    m_req_d    = 1'b0;
                    m_byteen_d = 4'b0000;
                    state_d    = IDLE;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    bus_err_d  = 1'b1;
                    m_req_d    = 1'b0;
                    m_byteen_d = 4'b0000;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            m_req_q    <= 1'b0;
            m_addr_q   <= 32'd0;
            m_wdata_q  <= 32'd0;
            m_byteen_q <= 4'b0000;
            exc_q      <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_req_q    <= m_req_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_byteen_q <= m_byteen_d;
            exc_q      <= exc_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign m_req     = m_req_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_byteen  = m_byteen_q;
    assign exc_ades  = exc_q;
    assign bus_err   = bus_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Testbench for store_align_unit (TIMEOUT=4): table vectors, hand-written
// reset/idle-ack sequences and random stores checked against a lane model.
module tb_store_align_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = 32'd0;
    logic [31:0] in_data = 32'd0;
    logic [1:0]  in_type = 2'b00;
    logic        m_req;
    logic        m_ack = 1'b0;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byteen;
    logic        exc_ades;
    logic        bus_err;
    logic [0:0]  dbg_state;

    int pass_cnt = 0;
    int total_cnt = 0;

    store_align_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_type(in_type),
        .m_req(m_req), .m_ack(m_ack), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_byteen(m_byteen),
        .exc_ades(exc_ades), .bus_err(bus_err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  typ;
        int          delay;   // ack raised in WAIT cycle delay+1
        logic        req;
        logic        exc;
        logic [31:0] wdata;
        logic [3:0]  be;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: lane placement from access size and byte offset.
    task automatic model(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] typ,
                         output logic req, output logic exc,
                         output logic [31:0] wdata, output logic [3:0] be);
        int off;
        bit mis;
        off = int'(addr % 4);
        req = 1'b0; exc = 1'b0; wdata = 32'd0; be = 4'd0;
        if (typ == 2'd3) return;
`ifdef STORE_ALIGN_EXC_EN
        mis = (typ == 2'd0 && off != 0) || (typ == 2'd1 && (off % 2) != 0);
`else
        mis = 1'b0;
`endif
        if (mis) begin
            exc = 1'b1;
            return;
        end
        req = 1'b1;
        if (typ == 2'd2) begin
            wdata = (data & 32'hFF) * 32'h0101_0101;
            be    = 4'(1 << off);
        end else if (typ == 2'd1) begin
            wdata = (data & 32'hFFFF) * 32'h0001_0001;
            be    = (off >= 2) ? 4'd12 : 4'd3;
        end else begin
            wdata = data;
            be    = 4'd15;
        end
    endtask

    // Driver + checker for one store, starting in IDLE at posedge+1.
    task automatic run_txn(input string nm, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] typ, input int delay,
                           input logic req, input logic exc,
                           input logic [31:0] wdata, input logic [3:0] be);
        bit acked;
        chk({nm, ".ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_addr = addr; in_data = data; in_type = typ;
        step();
        in_valid = 1'b0; in_addr = $urandom; in_data = $urandom; in_type = 2'(($urandom));
        chk({nm, ".req"}, 32'(m_req), 32'(req));
        chk({nm, ".exc"}, 32'(exc_ades), 32'(exc));
        chk({nm, ".buserr0"}, 32'(bus_err), 32'd0);
        if (!req) begin
            chk({nm, ".ready_idle"}, 32'(in_ready), 32'd1);
            chk({nm, ".be_idle"}, 32'(m_byteen), 32'd0);
            step();
            chk({nm, ".exc_pulse_end"}, 32'(exc_ades), 32'd0);
            chk({nm, ".noreq_later"}, 32'(m_req), 32'd0);
            return;
        end
        chk({nm, ".addr"}, m_addr, addr & 32'hFFFF_FFFC);
        chk({nm, ".wdata"}, m_wdata, wdata);
        chk({nm, ".be"}, 32'(m_byteen), 32'(be));
        chk({nm, ".ready_wait"}, 32'(in_ready), 32'd0);
        acked = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            if (k - 1 == delay) begin
                m_ack = 1'b1;
                step();
                m_ack = 1'b0;
                chk({nm, ".req_after_ack"}, 32'(m_req), 32'd0);
                chk({nm, ".be_after_ack"}, 32'(m_byteen), 32'd0);
                chk({nm, ".no_buserr"}, 32'(bus_err), 32'd0);
                chk({nm, ".ready_after_ack"}, 32'(in_ready), 32'd1);
                acked = 1'b1;
                break;
            end
            step();
            if (k < TO) begin
                chk({nm, ".hold_req"}, 32'(m_req), 32'd1);
                chk({nm, ".hold_data"}, {m_wdata[27:0], m_byteen}, {wdata[27:0], be});
            end
        end
        if (!acked) begin
            chk({nm, ".buserr"}, 32'(bus_err), 32'd1);
            chk({nm, ".req_after_to"}, 32'(m_req), 32'd0);
            chk({nm, ".be_after_to"}, 32'(m_byteen), 32'd0);
            chk({nm, ".ready_after_to"}, 32'(in_ready), 32'd1);
            chk({nm, ".exc_not_with_buserr"}, 32'(exc_ades), 32'd0);
            step();
            chk({nm, ".buserr_pulse_end"}, 32'(bus_err), 32'd0);
        end
    endtask

    initial begin
        logic        r, e;
        logic [31:0] w;
        logic [3:0]  be;
        logic [31:0] a, d;
        logic [1:0]  t;
        int          dl;

        // Table: addr, data, type, ack delay, req, exc, wdata, byteen
        vecs[0] = '{32'h0000_1003, 32'h0000_00AB, 2'd2, 0, 1'b1, 1'b0, 32'hABAB_ABAB, 4'b1000};
        vecs[1] = '{32'h0000_2002, 32'h0000_1234, 2'd1, 2, 1'b1, 1'b0, 32'h1234_1234, 4'b1100};
`ifdef STORE_ALIGN_EXC_EN
        vecs[2] = '{32'h0000_3001, 32'hDEAD_BEEF, 2'd0, 1, 1'b0, 1'b1, 32'h0, 4'b0000};
        vecs[7] = '{32'h0000_6003, 32'h0000_00CC, 2'd1, 0, 1'b0, 1'b1, 32'h0, 4'b0000};
`else
        vecs[2] = '{32'h0000_3001, 32'hDEAD_BEEF, 2'd0, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b1111};
        vecs[7] = '{32'h0000_6003, 32'h0000_00CC, 2'd1, 0, 1'b1, 1'b0, 32'h00CC_00CC, 4'b1100};
`endif
        vecs[3] = '{32'h0000_1000, 32'h0000_005A, 2'd2, 3, 1'b1, 1'b0, 32'h5A5A_5A5A, 4'b0001};
        vecs[4] = '{32'h0000_4000, 32'hFFFF_8765, 2'd1, 0, 1'b1, 1'b0, 32'h8765_8765, 4'b0011};
        vecs[5] = '{32'h0000_4001, 32'h1234_5677, 2'd2, 4, 1'b1, 1'b0, 32'h7777_7777, 4'b0010};
        vecs[6] = '{32'h0000_5000, 32'hCAFE_F00D, 2'd3, 0, 1'b0, 1'b0, 32'h0, 4'b0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req", 32'(m_req), 32'd0);
        chk("rst.addr", m_addr, 32'd0);
        chk("rst.wdata", m_wdata, 32'd0);
        chk("rst.be", 32'(m_byteen), 32'd0);
        chk("rst.exc", 32'(exc_ades), 32'd0);
        chk("rst.buserr", 32'(bus_err), 32'd0);
        chk("rst.ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        step();

        // Table vectors, back-to-back (next store offered the cycle after ack)
        foreach (vecs[i])
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].typ,
                    vecs[i].delay, vecs[i].req, vecs[i].exc, vecs[i].wdata, vecs[i].be);

        // m_ack in IDLE is ignored
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        chk("idle_ack.req", 32'(m_req), 32'd0);
        chk("idle_ack.ready", 32'(in_ready), 32'd1);
        chk("idle_ack.buserr", 32'(bus_err), 32'd0);

        // Reset while in WAIT drops the store; a late ack is ignored
        in_valid = 1'b1; in_addr = 32'h0000_7000; in_data = 32'h1111_2222; in_type = 2'd0;
        step();
        in_valid = 1'b0;
        chk("rstwait.req_set", 32'(m_req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstwait.req", 32'(m_req), 32'd0);
        chk("rstwait.be", 32'(m_byteen), 32'd0);
        chk("rstwait.ready", 32'(in_ready), 32'd1);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        chk("rstwait.late_ack_req", 32'(m_req), 32'd0);
        chk("rstwait.late_ack_buserr", 32'(bus_err), 32'd0);
        step();
        chk("rstwait.no_timeout", 32'(bus_err), 32'd0);

        // Random stores against the reference model
        for (int n = 0; n < 80; n++) begin
            a  = $urandom;
            d  = $urandom;
            t  = 2'($urandom_range(0, 3));
            dl = $urandom_range(0, TO + 1);
            model(a, d, t, r, e, w, be);
            run_txn($sformatf("rnd%0d", n), a, d, t, dl, r, e, w, be);
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", pass_cnt, total_cnt);
        $fatal(1, "time limit");
    end

endmodule
